// File: rtl/demux_tdm_1a4.sv
// demux_tdm_1a4 -- receive end of a 4-to-1 TDM link.
// Rebuilds one 4-slot frame from the word stream and presents it on four
// parallel outputs. Frame alignment comes from a start-of-frame marker on
// slot 0. Sync loss is detected and counted.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid          in_data / in_sof are valid this cycle
//   in_data [WIDTH]   multiplexed channel word
//   in_sof            word is slot 0 of a frame
//   out1..out4        channel words of the last complete frame
//   frame_valid       1-cycle pulse when out1..out4 have just been updated
//   locked            aligned to the frame marker
//   sync_err          1-cycle pulse when a framing violation is detected
//   err_cnt [ERR_W]   saturating count of sync_err pulses
module demux_tdm_1a4 #(
  parameter int WIDTH = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sof,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [1:0]                 slot_q, slot_d;
  // Slots 0..2 wait here; slot 3 goes straight to the outputs.
  logic [2:0][WIDTH-1:0]      shadow_q, shadow_d;
  logic [3:0][WIDTH-1:0]      out_q, out_d;
  logic                       frame_valid_q, frame_valid_d;
  logic                       sync_err_q, sync_err_d;
  logic [ERR_W-1:0]           err_cnt_q, err_cnt_d;

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    out_d         = out_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    err_cnt_d     = err_cnt_q;

    if (in_valid) begin
      case (state_q)
        HUNT: begin
          // In HUNT, words without the marker are dropped silently.
          if (in_sof) begin
            shadow_d[0] = in_data;
            slot_d      = 2'd1;
            state_d     = LOCKED;
          end
        end
        LOCKED: begin
          if (in_sof) begin
            // A marker always starts a new frame. Before slot 0 it is a
            // resync: the partial frame is lost, but lock is kept.
            if (slot_q != 2'd0) sync_err_d = 1'b1;
            shadow_d[0] = in_data;
            slot_d      = 2'd1;
          end else begin
            case (slot_q)
              2'd0: begin
                sync_err_d = 1'b1;
                state_d    = HUNT;
              end
              2'd1: begin
                shadow_d[1] = in_data;
                slot_d      = 2'd2;
              end
              2'd2: begin
                shadow_d[2] = in_data;
                slot_d      = 2'd3;
              end
              default: begin
                out_d         = {in_data, shadow_q[2], shadow_q[1], shadow_q[0]};
                frame_valid_d = 1'b1;
                slot_d        = 2'd0;
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // err_cnt updates on the same edge that raises sync_err.
    if (sync_err_d && (err_cnt_q != {ERR_W{1'b1}}))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      slot_q        <= 2'd0;
      shadow_q      <= '0;
      out_q         <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      out_q         <= out_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign out1        = out_q[0];
  assign out2        = out_q[1];
  assign out3        = out_q[2];
  assign out4        = out_q[3];
  assign frame_valid = frame_valid_q;
  assign locked      = (state_q == LOCKED);
  assign sync_err    = sync_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_demux_tdm_1a4.sv
module tb_demux_tdm_1a4;
  localparam int WIDTH = 8;
  localparam int ERR_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_sof = 1'b0;
  logic [WIDTH-1:0] out1, out2, out3, out4;
  logic             frame_valid, locked, sync_err;
  logic [ERR_W-1:0] err_cnt;

  int checks = 0;
  int errors = 0;

  demux_tdm_1a4 #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .out1(out1), .out2(out2), .out3(out3), .out4(out4),
    .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one word; keeps in_valid high so successive calls are back-to-back.
  task automatic send(input logic [WIDTH-1:0] d, input logic sof);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] outs();
    return {out1, out2, out3, out4};
  endfunction

  initial begin
    logic [WIDTH-1:0] pat [4];

    // 1: reset state, non-sof words ignored in HUNT
    #2 rst = 1'b1;
    #10 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_outs", outs(), 32'h0);
    chk("rst_flags", {frame_valid, locked, sync_err}, 3'b000);
    chk("rst_errcnt", err_cnt, 8'd0);
    send(8'h99, 1'b0);
    send(8'h98, 1'b0);
    idle(0);
    chk("hunt_outs", outs(), 32'h0);
    chk("hunt_flags", {frame_valid, locked, sync_err}, 3'b000);

    // 2: back-to-back frame
    send(8'h11, 1'b1);
    chk("lock_after_sof", locked, 1'b1);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    chk("no_fv_early", frame_valid, 1'b0);
    send(8'h44, 1'b0);
    idle(0);
    chk("f1_outs", outs(), 32'h11223344);
    chk("f1_fv", {frame_valid, locked, sync_err}, 3'b110);
    idle(1);
    chk("f1_fv_pulse", frame_valid, 1'b0);
    chk("f1_hold", outs(), 32'h11223344);

    // 3: same shape, gaps of 0..3 idle cycles; outputs hold until slot 3
    send(8'h55, 1'b1); idle(0);
    send(8'h66, 1'b0); idle(1);
    send(8'h77, 1'b0); idle(2);
    chk("gap_hold", outs(), 32'h11223344);
    chk("gap_no_fv", frame_valid, 1'b0);
    idle(1);
    send(8'h88, 1'b0); idle(0);
    chk("gap_outs", outs(), 32'h55667788);
    chk("gap_fv", frame_valid, 1'b1);

    // 4: early sof resyncs with error, then sof missing at slot 0
    send(8'hA1, 1'b1);
    send(8'hA2, 1'b0);
    send(8'hB1, 1'b1);
    chk("resync_err", {sync_err, locked, frame_valid}, 3'b110);
    chk("resync_cnt", err_cnt, 8'd1);
    send(8'hB2, 1'b0);
    chk("err_pulse", sync_err, 1'b0);
    send(8'hB3, 1'b0);
    send(8'hB4, 1'b0);
    chk("resync_outs", outs(), 32'hB1B2B3B4);
    chk("resync_fv", {frame_valid, sync_err}, 2'b10);
    send(8'h5A, 1'b0);
    idle(0);
    chk("slot0_err", {sync_err, locked, frame_valid}, 3'b100);
    chk("slot0_cnt", err_cnt, 8'd2);
    chk("slot0_outs", outs(), 32'hB1B2B3B4);

    // 5: async reset mid-frame
    send(8'hC1, 1'b1);
    send(8'hC2, 1'b0);
    idle(0);
    #2 rst = 1'b1;
    #1;
    chk("async_outs", outs(), 32'h0);
    chk("async_flags", {locked, err_cnt}, 9'h0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    send(8'hD1, 1'b1);
    send(8'hD2, 1'b0);
    send(8'hD3, 1'b0);
    send(8'hD4, 1'b0);
    idle(0);
    chk("post_rst_outs", outs(), 32'hD1D2D3D4);
    chk("post_rst_fv", frame_valid, 1'b1);

    // 6: loopback through a 4:1 mux model, continuous in_valid
    for (int p = 0; p < 16; p++) begin
      for (int k = 0; k < 4; k++) pat[k] = p[k] ? 8'hFF : 8'h00;
      for (int sel = 0; sel < 4; sel++) begin
        send(pat[sel], sel == 0);
        chk("lb_fv", frame_valid, sel == 3);
      end
      chk("lb_outs", outs(), {pat[0], pat[1], pat[2], pat[3]});
    end
    idle(0);
    chk("lb_noerr", err_cnt, 8'd0);

    // err_cnt saturation: repeated sof after slot 0 keeps flagging resync
    send(8'h01, 1'b1);
    for (int i = 0; i < 300; i++) send(8'h02, 1'b1);
    idle(0);
    chk("sat_cnt", err_cnt, 8'hFF);
    chk("sat_locked", locked, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
